// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared definitions for the load/store access master: op code constants,
// FSM state encoding, access-size encoding and small op decode helpers used
// by both lsu_dm_master and lsu_lane.
package lsu_pkg;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW,
    ST_WRITE,
    ST_RESP
  } lsuState_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } lsuSize_t;

  // Stores are exactly the three codes with the top bit set and a non-zero
  // low part; LW (100) is the only top-bit-set load.
  function automatic logic isStore(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Access width of an op, independent of load/store direction.
  function automatic lsuSize_t accessSize(input logic [2:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

  // Only LB and LH sign-extend; every other load is zero-extended.
  function automatic logic isSignedLoad(input logic [2:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  // Halves need an even address, words a multiple of four.
  function automatic logic isMisaligned(input logic [2:0] op, input logic [1:0] offset);
    case (accessSize(op))
      SZ_HALF: return offset[0];
      SZ_WORD: return |offset;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane
// Purely combinational big-endian lane logic for the LSU.
//   size       : access width (byte / half / word)
//   signedLoad : sign-extend the selected lane instead of zero-extending
//   offset     : byte offset within the word (0 = bits [31:24])
//   rdata      : word read from memory
//   wdata      : right-aligned store data (byte in [7:0], half in [15:0])
//   loadData   : selected and extended load result
//   mergedData : rdata with the addressed lane replaced by the store data
module lsu_lane
  import lsu_pkg::*;
(
  input  lsuSize_t    size,
  input  logic        signedLoad,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  output logic [31:0] loadData,
  output logic [31:0] mergedData
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Pick the addressed byte and half out of the read word. Offset 0 is the
  // most significant lane because the memory is big-endian.
  always_comb begin
    byteSel = rdata[31:24];
    case (offset)
      2'd0: byteSel = rdata[31:24];
      2'd1: byteSel = rdata[23:16];
      2'd2: byteSel = rdata[15:8];
      2'd3: byteSel = rdata[7:0];
      default: byteSel = rdata[31:24];
    endcase
    halfSel = offset[1] ? rdata[15:0] : rdata[31:16];
  end

  // Build the extended load value and the read-modify-write word. For word
  // accesses the merge path is never used, so it simply passes rdata through.
  always_comb begin
    loadData   = rdata;
    mergedData = rdata;
    case (size)
      SZ_BYTE: begin
        loadData = {{24{signedLoad & byteSel[7]}}, byteSel};
        case (offset)
          2'd0: mergedData = {wdata[7:0], rdata[23:0]};
          2'd1: mergedData = {rdata[31:24], wdata[7:0], rdata[15:0]};
          2'd2: mergedData = {rdata[31:16], wdata[7:0], rdata[7:0]};
          2'd3: mergedData = {rdata[31:8], wdata[7:0]};
          default: mergedData = rdata;
        endcase
      end
      SZ_HALF: begin
        loadData   = {{16{signedLoad & halfSel[15]}}, halfSel};
        mergedData = offset[1] ? {rdata[31:16], wdata[15:0]} : {wdata[15:0], rdata[15:0]};
      end
      default: begin
        loadData   = rdata;
        mergedData = rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_dm_master.sv
// lsu_dm_master
// Load/store access master between the MEM stage and a word-organised data
// memory. One request at a time; sub-word stores are read-modify-write.
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/req_ready           : request handshake (ready only in IDLE)
//   req_op, req_addr, req_wdata   : op code, byte address, right-aligned data
//   resp_valid/resp_ready         : response handshake
//   resp_rdata, resp_err          : extended load data, misalignment flag
//   mem_addr, mem_wdata, mem_we   : word port to memory
//   mem_rdata                     : combinational memory read of mem_addr
module lsu_dm_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  lsuState_t   state;
  logic [2:0]  opReg;
  logic [1:0]  offsetReg;
  logic [15:0] wdataReg;
  logic        weReg;
  lsuSize_t    opSize;
  logic        opSigned;
  logic [31:0] laneLoad;
  logic [31:0] laneMerged;

  assign opSize   = accessSize(opReg);
  assign opSigned = isSignedLoad(opReg);

  lsu_lane uLane (
    .size       (opSize),
    .signedLoad (opSigned),
    .offset     (offsetReg),
    .rdata      (mem_rdata),
    .wdata      (wdataReg),
    .loadData   (laneLoad),
    .mergedData (laneMerged)
  );

  // The write strobe is registered, but a reset arriving during the WRITE
  // cycle must still stop the memory from being written on that edge, so the
  // strobe is masked by rst directly.
  assign mem_we = weReg & ~rst;

  // Main FSM. All handshake and memory-port outputs are registers updated
  // here. Only the low half of the store data is kept because word stores
  // are launched straight from req_wdata on the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      weReg      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      opReg      <= OP_LB;
      offsetReg  <= '0;
      wdataReg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            opReg      <= req_op;
            offsetReg  <= req_addr[1:0];
            wdataReg   <= req_wdata[15:0];
            mem_addr   <= req_addr[ADDR_W-1:2];
            req_ready  <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            if (isMisaligned(req_op, req_addr[1:0])) begin
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end else if (!isStore(req_op)) begin
              state <= ST_LOAD;
            end else if (req_op == OP_SW) begin
              weReg     <= 1'b1;
              mem_wdata <= req_wdata;
              state     <= ST_WRITE;
            end else begin
              state <= ST_RMW;
            end
          end
        end
        ST_LOAD: begin
          resp_rdata <= laneLoad;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RMW: begin
          mem_wdata <= laneMerged;
          weReg     <= 1'b1;
          state     <= ST_WRITE;
        end
        ST_WRITE: begin
          weReg      <= 1'b0;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            mem_addr   <= '0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          weReg      <= 1'b0;
          mem_addr   <= '0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dm_master.sv
// tb_lsu_dm_master
// Self-checking bench for lsu_dm_master. A bench-side 1K-word memory serves
// the DUT; a reference memory plus an arithmetic access model supplies every
// expected value. Each scenario task drives and checks its own results.
module tb_lsu_dm_master;
  import lsu_pkg::*;

  localparam int ADDR_W = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem    [1024];
  logic [31:0] refMem [1024];
  logic        tbWe;
  logic [9:0]  tbAddr;
  logic [31:0] tbData;

  int checks   = 0;
  int failures = 0;

  lsu_dm_master #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Bench memory: combinational read, write on the clock edge. The bench can
  // also load words through its own port while the DUT is idle.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (tbWe) mem[tbAddr] <= tbData;
  end

  function automatic int countMemDiffs();
    int n = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== refMem[i]) n++;
    return n;
  endfunction

  task automatic pokeWord(input int idx, input logic [31:0] data);
    @(negedge clk);
    tbWe = 1'b1; tbAddr = 10'(idx); tbData = data;
    refMem[idx] = data;
    @(negedge clk);
    tbWe = 1'b0;
  endtask

  // Reference model: byte offset b of a size-byte field sits at bit
  // (4-b-size)*8 in a big-endian word. Updates refMem for stores.
  task automatic refAccess(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                           output logic [31:0] expData, output logic expErr, output int expLat,
                           output int expWe, output int expWeCyc);
    int size, off, shift;
    logic [31:0] mask, word, field;
    bit isSt;
    size  = (op == OP_LW || op == OP_SW) ? 4 : (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 1;
    isSt  = (op == OP_SB || op == OP_SH || op == OP_SW);
    off   = int'(addr[1:0]);
    word  = refMem[addr[11:2]];
    mask  = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (size * 8)) - 32'd1);
    expData = '0; expErr = 1'b0; expWe = 0; expWeCyc = -1; expLat = 0;
    if (off % size != 0) begin
      expErr = 1'b1;
      expLat = 1;
    end else if (!isSt) begin
      shift = (4 - off - size) * 8;
      field = (word >> shift) & mask;
      if ((op == OP_LB || op == OP_LH) && field[size*8-1]) field = field | ~mask;
      expData = field;
      expLat  = 2;
    end else begin
      shift = (4 - off - size) * 8;
      refMem[addr[11:2]] = (word & ~(mask << shift)) | ((wdata & mask) << shift);
      expWe    = 1;
      expWeCyc = (size == 4) ? 1 : 2;
      expLat   = expWeCyc + 1;
    end
  endtask

  // Drive one request, observe latency/strobe timing, optionally stall the
  // response, then complete the handshake. holdValid keeps a junk request
  // pending throughout to show nothing extra gets accepted.
  task automatic doAccess(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                          input int stall, input bit holdValid,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int weCnt, output int weCyc, output bit stable, output bit readyAfter);
    logic [9:0] heldAddr;
    lat = -1; weCnt = 0; weCyc = -1; stable = 1'b1; readyAfter = 1'b0; rdata = '0; err = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    if (!req_ready) stable = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      req_valid = holdValid; req_op = 3'($urandom); req_addr = 12'($urandom); req_wdata = $urandom;
      if (req_ready) stable = 1'b0;
      if (mem_we) begin weCnt++; weCyc = k; end
      if (resp_valid) begin lat = k; break; end
    end
    if (lat < 0) begin
      req_valid = 1'b0;
      return;
    end
    rdata = resp_rdata; err = resp_err; heldAddr = mem_addr;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (!resp_valid || resp_rdata !== rdata || resp_err !== err || req_ready || mem_we || mem_addr !== heldAddr)
        stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    readyAfter = req_ready && !resp_valid;
    req_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    tbWe = 1'b0; tbAddr = '0; tbData = '0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      tbWe = 1'b1; tbAddr = 10'(i); tbData = $urandom; refMem[i] = tbData;
    end
    @(negedge clk);
    tbWe = 1'b0;
    checks++;
    if ({req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0}) begin
      failures++;
      $display("[TB] FAIL reset_held: ready=%b rv=%b rdata=%h err=%b we=%b addr=%h wdata=%h, required 1 0 0 0 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0}) begin
      failures++;
      $display("[TB] FAIL reset_released: ready=%b rv=%b rdata=%h err=%b we=%b addr=%h wdata=%h, required 1 0 0 0 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if (countMemDiffs() != 0) begin
      failures++;
      $display("[TB] FAIL preload: differing words=%0d, required 0", countMemDiffs());
    end
  endtask

  // Runs one access against the model and checks every observed property.
  // Returns the observed load data so scenario tasks can add literal checks.
  task automatic test_access(input string name, input logic [2:0] op, input logic [11:0] addr,
                             input logic [31:0] wdata, input int stall, input bit holdValid,
                             output logic [31:0] rd);
    logic [31:0] eRd; logic er, eEr; int lat, eLat, weC, eWe, weCy, eWeCy; bit stb, rdyA;
    refAccess(op, addr, wdata, eRd, eEr, eLat, eWe, eWeCy);
    doAccess(op, addr, wdata, stall, holdValid, rd, er, lat, weC, weCy, stb, rdyA);
    checks++;
    if (rd !== eRd || er !== eEr || lat != eLat || weC != eWe || weCy != eWeCy || !stb || !rdyA) begin
      failures++;
      $display("[TB] FAIL %s: op=%0d addr=%h got rdata=%h err=%b lat=%0d we=%0d@%0d stable=%0b readyAfter=%0b, required rdata=%h err=%b lat=%0d we=%0d@%0d stable=1 readyAfter=1",
               name, op, addr, rd, er, lat, weC, weCy, stb, rdyA, eRd, eEr, eLat, eWe, eWeCy);
    end
    checks++;
    if (countMemDiffs() != 0) begin
      failures++;
      $display("[TB] FAIL %s_mem: differing words=%0d, required 0", name, countMemDiffs());
    end
  endtask

  task automatic test_lb_lbu();
    logic [31:0] rd;
    pokeWord(5, 32'h8812_34F0);
    test_access("lb_014", OP_LB, 12'h014, $urandom, 0, 1'b0, rd);
    checks++;
    if (rd !== 32'hFFFF_FF88) begin failures++; $display("[TB] FAIL lb_literal: got %h, required FFFFFF88", rd); end
    test_access("lbu_017", OP_LBU, 12'h017, $urandom, 0, 1'b0, rd);
    checks++;
    if (rd !== 32'h0000_00F0) begin failures++; $display("[TB] FAIL lbu_literal: got %h, required 000000F0", rd); end
  endtask

  task automatic test_sb_rmw();
    logic [31:0] rd, wd;
    pokeWord(5, 32'h1122_3344);
    wd = ($urandom & 32'hFFFF_FF00) | 32'h0000_00AB;
    test_access("sb_015", OP_SB, 12'h015, wd, 0, 1'b0, rd);
    checks++;
    if (mem[5] !== 32'h11AB_3344) begin failures++; $display("[TB] FAIL sb_word5: got %h, required 11AB3344", mem[5]); end
  endtask

  task automatic test_sh_lh();
    logic [31:0] rd, orig;
    orig = $urandom;
    pokeWord(8, orig);
    test_access("sh_022", OP_SH, 12'h022, 32'hC3C3_8001, 1, 1'b0, rd);
    test_access("lh_022", OP_LH, 12'h022, $urandom, 0, 1'b0, rd);
    checks++;
    if (rd !== 32'hFFFF_8001) begin failures++; $display("[TB] FAIL lh_literal: got %h, required FFFF8001", rd); end
    test_access("lhu_020", OP_LHU, 12'h020, $urandom, 0, 1'b0, rd);
    checks++;
    if (rd !== {16'h0, orig[31:16]}) begin failures++; $display("[TB] FAIL lhu_literal: got %h, required %h", rd, {16'h0, orig[31:16]}); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd;
    test_access("lw_006", OP_LW, 12'h006, $urandom, 0, 1'b0, rd);
    test_access("sh_003", OP_SH, 12'h003, $urandom, 0, 1'b0, rd);
    test_access("lh_031", OP_LH, 12'h031, $urandom, 2, 1'b0, rd);
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    test_access("lw_stall", OP_LW, 12'h040, $urandom, 5, 1'b1, rd);
    test_access("lw_after_stall", OP_LW, 12'h044, $urandom, 0, 1'b0, rd);
  endtask

  task automatic test_reset_mid_op();
    int weSeen;
    logic [31:0] rd;
    pokeWord(12, $urandom);
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_SB; req_addr = 12'h031; req_wdata = $urandom;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    weSeen = mem_we ? 1 : 0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mem_we) weSeen++;
    end
    checks++;
    if (weSeen != 0 || countMemDiffs() != 0) begin
      failures++;
      $display("[TB] FAIL rst_in_rmw: we pulses=%0d differing words=%0d, required 0 and 0", weSeen, countMemDiffs());
    end
    checks++;
    if ({req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0}) begin
      failures++;
      $display("[TB] FAIL rst_in_rmw_outputs: ready=%b rv=%b rdata=%h err=%b we=%b addr=%h wdata=%h, required 1 0 0 0 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_SW; req_addr = 12'h030; req_wdata = ~refMem[12];
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    #1;
    weSeen = mem_we ? 1 : 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (weSeen != 0 || countMemDiffs() != 0 || !req_ready || resp_valid) begin
      failures++;
      $display("[TB] FAIL rst_in_write: we=%0d differing words=%0d ready=%b rv=%b, required 0 0 1 0",
               weSeen, countMemDiffs(), req_ready, resp_valid);
    end
    test_access("sb_after_rst", OP_SB, 12'h031, $urandom, 0, 1'b0, rd);
  endtask

  task automatic test_random();
    logic [31:0] rd;
    for (int i = 0; i < 80; i++) begin
      test_access("random", 3'($urandom_range(0, 7)), 12'($urandom_range(0, 127)), $urandom,
                  $urandom_range(0, 2), 1'($urandom_range(0, 1)), rd);
    end
  endtask

  initial begin
    test_reset();
    test_lb_lbu();
    test_sb_rmw();
    test_sh_lh();
    test_misaligned();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
